mips_multicycle_cu: RTL

//  Multi-cycle MIPS control unit: registered FSM sequencing FETCH/DECODE/EXEC/MEM/WB per instruction.

---
 rtl/mips_cu_pkg.sv | 79 +++++++
 rtl/mips_cu_decode.sv | 87 ++++++++
 rtl/mips_multicycle_cu.sv | 90 +++++++++
 3 files changed

// File: rtl/mips_cu_pkg.sv
// Shared types for the multi-cycle MIPS control unit: state encoding, opcode/func
// constants, select/ALUOp encodings, the control word and the next-state function.
package mips_cu_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
      S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JR
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_DIV   = 6'b011010;

   localparam logic [1:0] ALU_FUNC = 2'b00, ALU_ADD = 2'b01, ALU_SUB = 2'b10, ALU_SLT = 2'b11;
   localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_R31 = 2'b11;
   localparam logic [1:0] A_PC = 2'b00, A_RS = 2'b01, A_ZERO = 2'b10;
   localparam logic [1:0] B_RT = 2'b00, B_SIMM = 2'b01, B_IMMHI = 2'b10, B_FOUR = 2'b11;
   localparam logic [1:0] WB_MEM = 2'b00, WB_ALU = 2'b01, WB_PC = 2'b10;
   localparam logic [1:0] PC_ALU = 2'b00, PC_BR = 2'b01, PC_JMP = 2'b10, PC_RS = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       iord;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] sm1;
      logic [1:0] sm2;
      logic [1:0] sm3;
      logic [1:0] sm4;
      logic [1:0] sm5;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic logic known_opcode(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_ADDI, OP_SLTI, OP_LUI, OP_LW, OP_SW,
         OP_BEQ, OP_BNE, OP_J, OP_JAL: known_opcode = 1'b1;
         default:                      known_opcode = 1'b0;
      endcase
   endfunction

   function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                         input logic [5:0] fn, input logic ready);
      next_state = S_FETCH;
      case (s)
         S_FETCH:    next_state = ready ? S_DECODE : S_FETCH;
         S_DECODE:
            case (op)
               OP_RTYPE:                next_state = (fn == FN_JR) ? S_JR : S_EXEC_R;
               OP_ADDI, OP_SLTI, OP_LUI: next_state = S_EXEC_I;
               OP_LW, OP_SW:            next_state = S_MEM_ADDR;
               OP_BEQ, OP_BNE:          next_state = S_BRANCH;
               OP_J, OP_JAL:            next_state = S_JUMP;
               default:                 next_state = S_FETCH;
            endcase
         // mult/div results live in HI/LO, so there is nothing to write back
         S_EXEC_R:   next_state = (fn == FN_MULT || fn == FN_DIV) ? S_FETCH : S_WB_ALU;
         S_EXEC_I:   next_state = S_WB_ALU;
         S_MEM_ADDR: next_state = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   next_state = ready ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR:   next_state = ready ? S_FETCH : S_MEM_WR;
         default:    next_state = S_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/mips_cu_decode.sv
// Combinational state -> control word decode. Only FETCH (mem_ready) and
// BRANCH (zero) look at anything beyond the state and the held opcode.
module mips_cu_decode
   import mips_cu_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output ctrl_t       ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read = 1'b1;
            ctrl.sm2      = A_PC;
            ctrl.sm3      = B_FOUR;
            ctrl.alu_op   = ALU_ADD;
            ctrl.sm5      = PC_ALU;
            ctrl.ir_write = mem_ready;
            ctrl.pc_write = mem_ready;
         end
         S_DECODE: begin
            ctrl.sm2    = A_PC;
            ctrl.sm3    = B_SIMM;
            ctrl.alu_op = ALU_ADD;
         end
         S_EXEC_R: begin
            ctrl.sm2    = A_RS;
            ctrl.sm3    = B_RT;
            ctrl.alu_op = ALU_FUNC;
         end
         S_EXEC_I: begin
            ctrl.sm2    = (opcode == OP_LUI) ? A_ZERO : A_RS;
            ctrl.sm3    = (opcode == OP_LUI) ? B_IMMHI : B_SIMM;
            ctrl.alu_op = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
         end
         S_WB_ALU: begin
            ctrl.reg_write = 1'b1;
            ctrl.sm4       = WB_ALU;
            ctrl.sm1       = (opcode == OP_RTYPE) ? DST_RD : DST_RT;
         end
         S_MEM_ADDR: begin
            ctrl.sm2    = A_RS;
            ctrl.sm3    = B_SIMM;
            ctrl.alu_op = ALU_ADD;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_WB_MEM: begin
            ctrl.reg_write = 1'b1;
            ctrl.sm1       = DST_RT;
            ctrl.sm4       = WB_MEM;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_BRANCH: begin
            ctrl.sm2      = A_RS;
            ctrl.sm3      = B_RT;
            ctrl.alu_op   = ALU_SUB;
            ctrl.sm5      = PC_BR;
            ctrl.pc_write = (opcode == OP_BNE) ? ~zero : zero;
         end
         S_JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.sm5      = PC_JMP;
            if (opcode == OP_JAL) begin
               ctrl.reg_write = 1'b1;
               ctrl.sm1       = DST_R31;
               ctrl.sm4       = WB_PC;
            end
         end
         S_JR: begin
            ctrl.pc_write = 1'b1;
            ctrl.sm5      = PC_RS;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_cu.sv
// Multi-cycle MIPS control unit: state register, sticky illegal flag and output gating.
// Optional MIPSCU_PERF_CNT_EN adds cycle / retired-instruction counters.
module mips_multicycle_cu #(
   parameter int SEL_W   = 2,
   parameter int ALUOP_W = 2
`ifdef MIPSCU_PERF_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         func,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pcWrite,
   output logic               irWrite,
   output logic               iorD,
   output logic               regWrite,
   output logic               memRead,
   output logic               memWrite,
   output logic [SEL_W-1:0]   sm1,
   output logic [SEL_W-1:0]   sm2,
   output logic [SEL_W-1:0]   sm3,
   output logic [SEL_W-1:0]   sm4,
   output logic [SEL_W-1:0]   sm5,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               illegal
`ifdef MIPSCU_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   cyc_cnt,
   output logic [CNT_W-1:0]   instr_cnt
`endif
);
   import mips_cu_pkg::*;

   state_t state, nxt;
   ctrl_t  ctrl, ctrl_g;

   assign nxt = next_state(state, opcode, func, mem_ready);

   mips_cu_decode u_decode (
      .state     (state),
      .opcode    (opcode),
      .zero      (zero),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_FETCH;
         illegal <= 1'b0;
      end else begin
         state <= nxt;
         if (state == S_DECODE && !known_opcode(opcode))
            illegal <= 1'b1;
      end
   end

   // The reset state is FETCH, whose decode requests memory; hold everything low while in reset.
   assign ctrl_g   = rst ? ctrl : '0;
   assign pcWrite  = ctrl_g.pc_write;
   assign irWrite  = ctrl_g.ir_write;
   assign iorD     = ctrl_g.iord;
   assign regWrite = ctrl_g.reg_write;
   assign memRead  = ctrl_g.mem_read;
   assign memWrite = ctrl_g.mem_write;
   assign sm1      = SEL_W'(ctrl_g.sm1);
   assign sm2      = SEL_W'(ctrl_g.sm2);
   assign sm3      = SEL_W'(ctrl_g.sm3);
   assign sm4      = SEL_W'(ctrl_g.sm4);
   assign sm5      = SEL_W'(ctrl_g.sm5);
   assign ALUOp    = ALUOP_W'(ctrl_g.alu_op);

`ifdef MIPSCU_PERF_CNT_EN
   // An illegal opcode drops from DECODE back to FETCH and is not retired.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_cnt   <= '0;
         instr_cnt <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + CNT_W'(1);
         if (nxt == S_FETCH && state != S_FETCH && state != S_DECODE)
            instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
